// File: rtl/mem_arbiter_if.sv
// Signal bundle between the pipeline requesters, the memory arbiter and the shared RAM port.
// The arbiter connects through the slave modport; the environment drives the master side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Pipeline side.
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              halt;
  logic              iHit;
  logic [DATA_W-1:0] iload;
  logic              dHit;
  logic [DATA_W-1:0] dload;
  logic              err;
  logic              halted;

  // RAM side.
  logic [1:0]        ramstate;
  logic [DATA_W-1:0] ramload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramstate, ramload,
    output iHit, iload, dHit, dload, ramREN, ramWEN, ramaddr, ramstore, err, halted
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramstate, ramload,
    input  iHit, iload, dHit, dload, ramREN, ramWEN, ramaddr, ramstore, err, halted
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: serialises fetch and data requests (data first), holds the RAM
// command stable for the whole access, returns one-cycle hit pulses and handles halt/timeout.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);
  localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [1:0]       RAM_ACCESS = 2'd2;
  localparam logic [1:0]       RAM_ERROR  = 2'd3;
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, DACC, IACC, HALTED} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              pend_halt;

  logic              ihit, ihit_nxt;
  logic              dhit, dhit_nxt;
  logic              ren, ren_nxt;
  logic              wen, wen_nxt;
  logic              err, err_nxt;
  logic              halted, halted_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] store, store_nxt;
  logic [DATA_W-1:0] iload, iload_nxt;
  logic [DATA_W-1:0] dload, dload_nxt;

  logic halt_req, hit_busy, d_req, in_acc, got_access, got_error, timeout, done;

  assign halt_req   = pend_halt | bus.halt;
  // The requester still holds its request during the hit cycle, so IDLE must not resample it.
  assign hit_busy   = ihit | dhit;
  assign d_req      = bus.dREN | bus.dWEN;
  assign in_acc     = (state == DACC) || (state == IACC);
  assign got_access = (bus.ramstate == RAM_ACCESS);
  assign got_error  = (bus.ramstate == RAM_ERROR);
  assign timeout    = in_acc && !got_access && (wait_cnt == LAST_WAIT);
  assign done       = in_acc && (got_access || timeout);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      pend_halt <= 1'b0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      ren       <= 1'b0;
      wen       <= 1'b0;
      err       <= 1'b0;
      halted    <= 1'b0;
      addr      <= '0;
      store     <= '0;
      iload     <= '0;
      dload     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the pre-edge values.
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      pend_halt <= pend_halt | bus.halt;
      ihit      <= ihit_nxt;
      dhit      <= dhit_nxt;
      ren       <= ren_nxt;
      wen       <= wen_nxt;
      err       <= err_nxt;
      halted    <= halted_nxt;
      addr      <= addr_nxt;
      store     <= store_nxt;
      iload     <= iload_nxt;
      dload     <= dload_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!hit_busy) begin
          if (halt_req)      state_nxt = HALTED;
          else if (d_req)    state_nxt = DACC;
          else if (bus.iREN) state_nxt = IACC;
        end
      end
      DACC, IACC: if (done) state_nxt = IDLE;
      default:    state_nxt = HALTED;
    endcase
  end

  always_comb begin
    // NOTE: every value gets a default first so no path through the case infers a latch.
    ihit_nxt     = 1'b0;
    dhit_nxt     = 1'b0;
    ren_nxt      = ren;
    wen_nxt      = wen;
    err_nxt      = err;
    addr_nxt     = addr;
    store_nxt    = store;
    iload_nxt    = iload;
    dload_nxt    = dload;
    wait_cnt_nxt = wait_cnt;
    halted_nxt   = (state_nxt == HALTED);

    case (state)
      IDLE: begin
        ren_nxt = 1'b0;
        wen_nxt = 1'b0;
        if (!hit_busy && !halt_req) begin
          if (d_req) begin
            // A simultaneous read and write is carried out as the write and flagged.
            addr_nxt     = bus.daddr;
            store_nxt    = bus.dstore;
            wen_nxt      = bus.dWEN;
            ren_nxt      = bus.dREN & ~bus.dWEN;
            err_nxt      = err | (bus.dREN & bus.dWEN);
            wait_cnt_nxt = '0;
          end else if (bus.iREN) begin
            addr_nxt     = bus.iaddr;
            ren_nxt      = 1'b1;
            wait_cnt_nxt = '0;
          end
        end
      end

      DACC, IACC: begin
        if (got_error) err_nxt = 1'b1;
        if (done) begin
          ren_nxt      = 1'b0;
          wen_nxt      = 1'b0;
          wait_cnt_nxt = '0;
          if (timeout) err_nxt = 1'b1;
          if (state == IACC) begin
            ihit_nxt  = 1'b1;
            iload_nxt = timeout ? '0 : bus.ramload;
          end else begin
            dhit_nxt = 1'b1;
            if (timeout)  dload_nxt = '0;
            else if (!wen) dload_nxt = bus.ramload;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        ren_nxt = 1'b0;
        wen_nxt = 1'b0;
      end
    endcase
  end

  assign bus.iHit     = ihit;
  assign bus.dHit     = dhit;
  assign bus.iload    = iload;
  assign bus.dload    = dload;
  assign bus.ramREN   = ren;
  assign bus.ramWEN   = wen;
  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.err      = err;
  assign bus.halted   = halted;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized single accesses,
// with a transaction-level model of hit order, load values and the sticky error flag.
module tb_mem_arbiter;
  localparam int MAX_WAIT = 16;

  typedef struct packed {
    logic        is_d;
    logic [31:0] load;
    logic        err;
  } exp_t;

  logic CLK;
  logic nRST;
  int   vectors;
  int   miscompares;

  exp_t        sb[$];
  logic        err_m;
  logic [31:0] iload_m;
  logic [31:0] dload_m;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every hit must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (bus.iHit || bus.dHit) begin
      if (sb.size() == 0) begin
        check("spurious_hit", {bus.iHit, bus.dHit}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("hit_kind", {bus.iHit, bus.dHit}, e.is_d ? 2'b01 : 2'b10);
        check("hit_load", e.is_d ? bus.dload : bus.iload, e.load);
        check("hit_err", bus.err, e.err);
      end
    end
  end

  // Plays the RAM for one access: waits for the command, answers after 'busy' wait cycles
  // (never, if busy >= MAX_WAIT) and checks the command stays put until the hit.
  task automatic serve_one(input logic [31:0] exp_addr, input bit exp_ren, input bit exp_wen,
                           input logic [31:0] exp_store, input int busy, input int err_at,
                           input int halt_at, input int drop_at, input logic [31:0] rdata);
    int n;
    int lat;
    bit timed;
    timed = (busy >= MAX_WAIT);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(bus.ramREN || bus.ramWEN) && n < 10);
    check("issue_strobes", {bus.ramREN, bus.ramWEN}, {exp_ren, exp_wen});
    if (!(bus.ramREN || bus.ramWEN)) return;
    check("issue_addr", bus.ramaddr, exp_addr);
    if (exp_wen) check("issue_store", bus.ramstore, exp_store);
    lat = 0;
    while (!(bus.iHit || bus.dHit) && lat < 3 * MAX_WAIT) begin
      bus.ramload = $urandom;
      if (!timed && lat == busy) begin
        bus.ramstate = 2'd2;
        bus.ramload  = rdata;
      end else if (lat == err_at) begin
        bus.ramstate = 2'd3;
      end else begin
        bus.ramstate = 2'd1;
      end
      bus.halt = (lat == halt_at);
      if (lat == drop_at) begin
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
      end
      @(negedge CLK);
      lat++;
      if (!(bus.iHit || bus.dHit)) begin
        check("hold_addr", bus.ramaddr, exp_addr);
        check("hold_strobes", {bus.ramREN, bus.ramWEN}, {exp_ren, exp_wen});
        if (exp_wen) check("hold_store", bus.ramstore, exp_store);
      end
    end
    bus.ramstate = 2'd0;
    bus.halt     = 1'b0;
    check("hit_latency", lat, timed ? MAX_WAIT : busy + 1);
    check("strobes_at_hit", {bus.ramREN, bus.ramWEN}, 2'b00);
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 read+write together. Starts and ends on a falling edge.
  task automatic txn(input int kind, input logic [31:0] addr, input logic [31:0] data,
                     input int busy, input int err_at, input int drop_at, input int halt_at,
                     input logic [31:0] rdata);
    exp_t e;
    bit   timed;
    timed      = (busy >= MAX_WAIT);
    bus.iREN   = (kind == 0);
    bus.iaddr  = (kind == 0) ? addr : $urandom;
    bus.dREN   = (kind == 1 || kind == 3);
    bus.dWEN   = (kind >= 2);
    bus.daddr  = (kind == 0) ? $urandom : addr;
    bus.dstore = data;

    if (kind == 3 || (err_at >= 0 && err_at < busy) || timed) err_m = 1'b1;
    if (timed)          e.load = '0;
    else if (kind <= 1) e.load = rdata;
    else                e.load = dload_m;
    if (kind == 0) iload_m = e.load;
    else           dload_m = e.load;
    e.is_d = (kind != 0);
    e.err  = err_m;
    sb.push_back(e);

    serve_one(addr, kind <= 1, kind >= 2, data, busy, err_at, halt_at, drop_at, rdata);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    @(negedge CLK);
    check("iload_held", bus.iload, iload_m);
    check("dload_held", bus.dload, dload_m);
    check("err_sticky", bus.err, err_m);
  endtask

  initial begin
    exp_t e;
    int   r, busy, err_at, drop_at, n;

    vectors      = 0;
    miscompares  = 0;
    err_m        = 1'b0;
    iload_m      = '0;
    dload_m      = '0;
    nRST         = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.halt     = 1'b0;
    bus.ramstate = 2'd0;
    bus.ramload  = '0;

    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_ihit", bus.iHit, 0);
    check("rst_dhit", bus.dHit, 0);
    check("rst_ramren", bus.ramREN, 0);
    check("rst_ramwen", bus.ramWEN, 0);
    check("rst_ramaddr", bus.ramaddr, 0);
    check("rst_ramstore", bus.ramstore, 0);
    check("rst_iload", bus.iload, 0);
    check("rst_dload", bus.dload, 0);
    check("rst_err", bus.err, 0);
    check("rst_halted", bus.halted, 0);

    // Fetch only.
    txn(0, 32'h40, 32'h0, 2, -1, -1, -1, 32'h8C010004);

    // Fetch and load together: data is served first.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h44;
    bus.dREN  = 1'b1;
    bus.dWEN  = 1'b0;
    bus.daddr = 32'h100;
    e.is_d = 1'b1; e.load = 32'hA0A00100; e.err = err_m; sb.push_back(e);
    dload_m = 32'hA0A00100;
    e.is_d = 1'b0; e.load = 32'h8C000044; e.err = err_m; sb.push_back(e);
    iload_m = 32'h8C000044;
    serve_one(32'h100, 1'b1, 1'b0, 32'h0, 1, -1, -1, -1, 32'hA0A00100);
    bus.dREN = 1'b0;
    serve_one(32'h44, 1'b1, 1'b0, 32'h0, 1, -1, -1, -1, 32'h8C000044);
    bus.iREN = 1'b0;
    @(negedge CLK);

    // Store, then one ERROR cycle before ACCESS, then a stuck RAM, then read+write together.
    txn(2, 32'h200, 32'hDEADBEEF, 3, -1, -1, -1, $urandom);
    txn(1, 32'h304, 32'h0, 1, 0, -1, -1, 32'h12345678);
    txn(1, 32'h300, 32'h0, MAX_WAIT, -1, -1, -1, 32'hFFFFFFFF);
    txn(3, 32'h208, 32'hCAFEF00D, 1, -1, -1, -1, $urandom);
    txn(0, 32'h48, 32'h0, MAX_WAIT, 3, -1, -1, 32'h11111111);

    for (int i = 0; i < 40; i++) begin
      r       = $urandom_range(0, 9);
      busy    = ($urandom_range(0, 9) == 0) ? MAX_WAIT : int'($urandom_range(0, 5));
      err_at  = (busy > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, busy - 1)) : -1;
      drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, busy)) : -1;
      txn((r <= 3) ? 0 : (r <= 6) ? 1 : (r <= 8) ? 2 : 3,
          $urandom, $urandom, busy, err_at, drop_at, -1, $urandom);
    end

    // Asynchronous reset in the middle of a store.
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h280;
    bus.dstore = 32'h5555AAAA;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.ramWEN && n < 10);
    check("rst_mid_pre_wen", bus.ramWEN, 1);
    bus.ramstate = 2'd1;
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("rst_mid_wen", bus.ramWEN, 0);
    check("rst_mid_ren", bus.ramREN, 0);
    check("rst_mid_addr", bus.ramaddr, 0);
    check("rst_mid_err", bus.err, 0);
    sb.delete();
    err_m   = 1'b0;
    iload_m = '0;
    dload_m = '0;
    bus.dWEN     = 1'b0;
    bus.ramstate = 2'd0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (4) @(negedge CLK);
    check("rst_mid_dload", bus.dload, dload_m);
    txn(0, 32'h80, 32'h0, 1, -1, -1, -1, 32'h0BADF00D);

    // Halt pulse during a fetch: the fetch completes, then the arbiter stops for good.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'hC0;
    e.is_d = 1'b0; e.load = 32'h24080001; e.err = err_m; sb.push_back(e);
    iload_m = 32'h24080001;
    serve_one(32'hC0, 1'b1, 1'b0, 32'h0, 3, -1, 1, -1, 32'h24080001);
    check("halted_at_hit", bus.halted, 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      check("halt_strobes", {bus.ramREN, bus.ramWEN}, 2'b00);
      if (k >= 2) check("halted", bus.halted, 1);
    end
    check("halt_iload", bus.iload, iload_m);
    check("halt_queue_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
